l2_l1_refill_responder: RTL

//  L2-side source of the 512-bit refill line consumed by the L1 I-cache data array.
//  - Accepts a line-miss request from the L1 controller.
//  - Fetches the line from the backing memory as eight 64-bit beats and assembles it.
//  - Drives read_data_L2_L1 and pulses refill so the data array writes the line at its index.

---
 rtl/cache_pkg.sv | 19 +
 rtl/refill_line_buffer.sv | 26 ++
 rtl/l2_l1_refill_responder.sv | 101 ++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Cache line geometry and refill FSM encoding shared by the L2->L1 refill path.
package cache_pkg;

    localparam int LINE_BITS   = 512;
    localparam int BEAT_BITS   = 64;
    localparam int OFFSET_BITS = 6;
    localparam int BEATS       = LINE_BITS / BEAT_BITS;
    localparam int BEAT_IDX_W  = $clog2(BEATS);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/refill_line_buffer.sv
// Line register assembled one memory beat at a time; holds its contents
// between fills so the L1 can sample it on the refill strobe.
module refill_line_buffer
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_beat_we,
    input  logic [BEAT_IDX_W-1:0] i_beat_idx,
    input  logic [BEAT_BITS-1:0]  i_beat_data,
    output logic [LINE_BITS-1:0]  o_line
);

    logic [LINE_BITS-1:0] r_line;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_line <= '0;
        end else if (i_beat_we) begin
            r_line[i_beat_idx*BEAT_BITS +: BEAT_BITS] <= i_beat_data;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/l2_l1_refill_responder.sv
// L2-side refill responder: fetches a 64 B line as eight beats and strobes it into the L1.
//   state   | meaning
//   ST_IDLE | waiting for an L1 miss request
//   ST_REQ  | memory read request outstanding until mem_ready
//   ST_FILL | collecting return beats into the line buffer
//   ST_DONE | line complete, one-cycle refill strobe
module l2_l1_refill_responder
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  l1_req,
    input  logic [ADDR_WIDTH-1:0] l1_addr,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [BEAT_BITS-1:0]  mem_rdata,
    output logic [LINE_BITS-1:0]  read_data_L2_L1,
    output logic                  refill
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    refill_state_e         r_state;
    refill_state_e         w_next;
    logic [BEAT_IDX_W-1:0] r_beat_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  w_accept;
    logic                  w_beat_we;

    assign w_accept  = (r_state == ST_IDLE) && l1_req;
    assign w_beat_we = (r_state == ST_FILL) && mem_rvalid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (l1_req)    w_next = ST_REQ;
            ST_REQ:  if (mem_ready) w_next = ST_FILL;
            ST_FILL: if (w_beat_we && (r_beat_cnt == LAST_BEAT)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        mem_req = 1'b0;
        refill  = 1'b0;
        unique case (r_state)
            ST_IDLE: ;
            ST_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
            end
            ST_FILL: busy = 1'b1;
            ST_DONE: begin
                busy   = 1'b1;
                refill = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter wraps to 0 on the last beat, which is also the FILL exit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_base     <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_base     <= l1_addr & LINE_MASK;
            r_beat_cnt <= '0;
        end else if (w_beat_we) begin
            r_beat_cnt <= r_beat_cnt + BEAT_IDX_W'(1);
        end
    end

    assign mem_addr = r_base;

    refill_line_buffer u_line_buf (
        .clk         (clk),
        .nrst        (nrst),
        .i_beat_we   (w_beat_we),
        .i_beat_idx  (r_beat_cnt),
        .i_beat_data (mem_rdata),
        .o_line      (read_data_L2_L1)
    );

endmodule
